regfile_scoreboard_m: RTL and testbench

Parametrised, clocked register file for the datapath, with a per-register pending-write scoreboard. It provides two registered read ports, and port 2 has an integrated immediate/ALU-source mux. It has one write port and a hardwired zero register. Issue logic marks destinations busy when a multi-cycle op is launched, and writeback clears them; the block exports per-operand busy flags and a stall.

---
 rtl/regfile_scoreboard_m.sv | 136 +++++++++++++
 tb/tb_regfile_scoreboard_m.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_m.sv
// regfile_scoreboard_m
// Register file with a per-register pending-write scoreboard. It has two
// registered read ports (port 2 carries the immediate/ALU-source mux), one
// write port, and a hardwired-zero register. Issue marks a destination
// pending and writeback clears it. Per-operand busy flags and an advisory
// stall are exported, all registered.
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   : read data and busy flags forward the same-cycle write/issue
//   undefined : reads observe pre-edge array contents and pending bits
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   rd_addr1/rd_addr2   read indices
//   imm, alu_src        immediate for port 2 and its select (1 = imm)
//   wr_en/addr/data     write port
//   issue_en/addr       mark destination of a launched multi-cycle op
//   rd_data1/rd_data2   registered read data
//   busy1/busy2/stall   registered scoreboard status
module regfile_scoreboard_m #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy1,
  output logic              busy2,
  output logic              stall
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;

  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
  logic              busy1_q, busy1_d;
  logic              busy2_q, busy2_d;
  logic              stall_q, stall_d;

  logic wr_ok_c;
  logic issue_ok_c;

  // Writes and issues aimed at the zero register are dropped.
  assign wr_ok_c    = wr_en    && (wr_addr    != ZERO_A);
  assign issue_ok_c = issue_en && (issue_addr != ZERO_A);

  // Next-state array and scoreboard; issue is applied after the write so a
  // same-cycle issue to the written index leaves it pending (new producer).
  always_comb begin
    mem_d     = mem_q;
    pending_d = pending_q;
    if (wr_ok_c) begin
      mem_d[wr_addr]     = wr_data;
      pending_d[wr_addr] = 1'b0;
    end
    if (issue_ok_c) begin
      pending_d[issue_addr] = 1'b1;
    end
  end

  // Read data and busy flags; the bypass build reads the next-state copies.
  always_comb begin
    rd_data1_d = '0;
    rd_data2_d = '0;
    busy1_d    = 1'b0;
    busy2_d    = 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (rd_addr1 != ZERO_A) begin
      rd_data1_d = mem_d[rd_addr1];
      busy1_d    = pending_d[rd_addr1];
    end
    if (alu_src) begin
      rd_data2_d = imm;
    end else if (rd_addr2 != ZERO_A) begin
      rd_data2_d = mem_d[rd_addr2];
      busy2_d    = pending_d[rd_addr2];
    end
`else
    if (rd_addr1 != ZERO_A) begin
      rd_data1_d = mem_q[rd_addr1];
      busy1_d    = pending_q[rd_addr1];
    end
    if (alu_src) begin
      rd_data2_d = imm;
    end else if (rd_addr2 != ZERO_A) begin
      rd_data2_d = mem_q[rd_addr2];
      busy2_d    = pending_q[rd_addr2];
    end
`endif
    stall_d = busy1_d | busy2_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      pending_q  <= '0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      busy1_q    <= 1'b0;
      busy2_q    <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      pending_q  <= pending_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      busy1_q    <= busy1_d;
      busy2_q    <= busy2_d;
      stall_q    <= stall_d;
    end
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;
  assign busy1    = busy1_q;
  assign busy2    = busy2_q;
  assign stall    = stall_q;

endmodule

// File: tb/tb_regfile_scoreboard_m.sv
// Directed bench for regfile_scoreboard_m; expectations follow the bypass
// macro when the same-cycle behaviour differs.
module tb_regfile_scoreboard_m;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, issue_addr;
  logic [31:0] imm, wr_data;
  logic        alu_src, wr_en, issue_en;
  logic [31:0] rd_data1, rd_data2;
  logic        busy1, busy2, stall;

  int checks   = 0;
  int failures = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_scoreboard_m dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .imm(imm), .alu_src(alu_src),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .busy1(busy1), .busy2(busy2), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rd_data1"}, rd_data1, 32'h0);
    chk({tag, ".rd_data2"}, rd_data2, 32'h0);
    chk({tag, ".busy1"}, 32'(busy1), 32'h0);
    chk({tag, ".busy2"}, 32'(busy2), 32'h0);
    chk({tag, ".stall"}, 32'(stall), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; issue_addr = '0;
    imm = '0; wr_data = '0; alu_src = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
    tick(); tick();
    chk_all_zero("init_reset");
    rst_n = 1'b1;

    // Write reg 3, confirm it, then reset mid-run.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; rd_addr1 = 5'd3; rd_addr2 = 5'd3;
    tick();
    chk("pre_reset_r3", rd_data1, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    tick();
    chk_all_zero("held_reset");
    rst_n = 1'b1;
    tick();
    chk("post_reset_r3_p1", rd_data1, 32'h0);
    chk("post_reset_r3_p2", rd_data2, 32'h0);

    // Write reg 7, read next cycle on both ports.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    tick();
    wr_en = 1'b0; rd_addr1 = 5'd7; rd_addr2 = 5'd7;
    tick();
    chk("r7_p1", rd_data1, 32'h12345678);
    chk("r7_busy1", 32'(busy1), 32'h0);
    chk("r7_p2", rd_data2, 32'h12345678);

    // Same-cycle read-after-write of reg 5.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5A5A5A5; rd_addr1 = 5'd5;
    tick();
    chk("raw_same_cycle", rd_data1, BYP ? 32'hA5A5A5A5 : 32'h0);
    wr_en = 1'b0;
    tick();
    chk("raw_next_cycle", rd_data1, 32'hA5A5A5A5);

    // Zero register: write and issue are dropped.
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hFFFFFFFF;
    issue_en = 1'b1; issue_addr = 5'd31;
    rd_addr1 = 5'd31; rd_addr2 = 5'd31; alu_src = 1'b0;
    tick();
    chk_all_zero("zero_same_cycle");
    wr_en = 1'b0; issue_en = 1'b0;
    tick();
    chk_all_zero("zero_reg");

    // Scoreboard: issue reg 9, read on port 2.
    issue_en = 1'b1; issue_addr = 5'd9; rd_addr2 = 5'd0;
    tick();
    issue_en = 1'b0; rd_addr2 = 5'd9;
    tick();
    chk("sb_busy2", 32'(busy2), 32'h1);
    chk("sb_stall", 32'(stall), 32'h1);
    chk("sb_busy1_zero", 32'(busy1), 32'h0);
    alu_src = 1'b1; imm = 32'hFFFFFFFC;
    tick();
    chk("sb_imm", rd_data2, 32'hFFFFFFFC);
    chk("sb_imm_busy2", 32'(busy2), 32'h0);
    chk("sb_imm_stall", 32'(stall), 32'h0);
    alu_src = 1'b0; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000099;
    tick();
    chk("sb_wb_same_busy2", 32'(busy2), BYP ? 32'h1 - 32'h1 : 32'h1);
    chk("sb_wb_same_data", rd_data2, BYP ? 32'h99 : 32'h0);
    wr_en = 1'b0;
    tick();
    chk("sb_wb_busy2", 32'(busy2), 32'h0);
    chk("sb_wb_stall", 32'(stall), 32'h0);
    chk("sb_wb_data", rd_data2, 32'h99);

    // Issue visibility on port 1 for a fresh index.
    issue_en = 1'b1; issue_addr = 5'd20; rd_addr1 = 5'd20;
    tick();
    chk("issue_same_busy1", 32'(busy1), BYP ? 32'h1 : 32'h0);
    issue_en = 1'b0;
    tick();
    chk("issue_next_busy1", 32'(busy1), 32'h1);

    // Issue/write collision on reg 12: issue wins.
    issue_en = 1'b1; issue_addr = 5'd12; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h55;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    tick();
    issue_en = 1'b0; wr_en = 1'b0; rd_addr1 = 5'd12;
    tick();
    chk("coll_busy1", 32'(busy1), 32'h1);
    chk("coll_data", rd_data1, 32'h55);
    chk("coll_stall", 32'(stall), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
